if_stage: RTL and testbench

//  Instruction-fetch stage, directly upstream of instruction decode. Owns the PC,

---
 rtl/if_stage.sv | 128 ++++++++++++
 tb/tb_if_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues fetches under a credit limit,
// tracks PCs of in-flight requests and buffers {pc, inst} for decode.
// Redirects flush the stage; responses already in flight are counted and dropped.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;     // accepted requests not yet answered
    logic [CW-1:0] drop_q, drop_d;   // responses still to be discarded
    logic [CW-1:0] pwr_q, pwr_d, prd_q, prd_d;   // in-flight PC buffer pointers
    logic [CW-1:0] fwr_q, fwr_d, frd_q, frd_d;   // instruction FIFO pointers

    logic [63:0] ifl_pc_mem  [DEPTH];
    logic [63:0] fifo_pc_mem [DEPTH];
    logic [31:0] fifo_ins_mem[DEPTH];

    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   credit_used;
    logic          fire, rsp_ok, rsp_live, pop;

    assign fifo_cnt    = fwr_q - frd_q;
    // Outstanding requests plus buffered entries bound what the FIFO may need
    // to hold, so a push can never find it full.
    assign credit_used = {1'b0, out_q} + {1'b0, fifo_cnt};

    assign imem_req_valid = rst_n & ~redirect_valid & (credit_used < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid & imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok         = imem_rsp_valid & (out_q != '0);
    assign rsp_live       = rsp_ok & (drop_q == '0);
    assign if_valid       = (fifo_cnt != '0);
    assign pop            = if_valid & id_ready;
    assign if_pc          = if_valid ? fifo_pc_mem[frd_q[AW-1:0]] : 64'd0;
    assign if_inst        = if_valid ? fifo_ins_mem[frd_q[AW-1:0]] : NOP;

    // Next-state: redirect overrides issue, push and pop in the same cycle.
    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q;
        drop_d = drop_q;
        pwr_d  = pwr_q;
        prd_d  = prd_q;
        fwr_d  = fwr_q;
        frd_d  = frd_q;
        if (redirect_valid) begin
            pc_d   = {redirect_pc[63:2], 2'b00};
            out_d  = out_q - CW'(rsp_ok);
            // Everything still in flight after this cycle belongs to the old
            // path. When that is zero, the old drop_cnt can only be zero too
            // (or be consumed by this cycle's response), so loading is exact.
            drop_d = out_q - CW'(rsp_ok);
            pwr_d  = '0;
            prd_d  = '0;
            fwr_d  = '0;
            frd_d  = '0;
        end else begin
            if (fire) begin
                pc_d  = pc_q + 64'd4;
                pwr_d = pwr_q + CW'(1);
            end
            out_d = out_q + CW'(fire) - CW'(rsp_ok);
            if (rsp_ok && drop_q != '0)
                drop_d = drop_q - CW'(1);
            if (rsp_live) begin
                prd_d = prd_q + CW'(1);
                fwr_d = fwr_q + CW'(1);
            end
            if (pop)
                frd_d = frd_q + CW'(1);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
            pwr_q  <= '0;
            prd_q  <= '0;
            fwr_q  <= '0;
            frd_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            pwr_q  <= pwr_d;
            prd_q  <= prd_d;
            fwr_q  <= fwr_d;
            frd_q  <= frd_d;
        end
    end

    // Data storage; validity is carried entirely by the pointers above.
    always_ff @(posedge clk) begin
        if (fire)
            ifl_pc_mem[pwr_q[AW-1:0]] <= pc_q;
        if (rsp_live && !redirect_valid) begin
            fifo_pc_mem[fwr_q[AW-1:0]]  <= ifl_pc_mem[prd_q[AW-1:0]];
            fifo_ins_mem[fwr_q[AW-1:0]] <= imem_rsp_data;
        end
    end

    a_rsp_without_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) !(imem_rsp_valid && out_q == '0));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: in-order queue memory model with a hold
// control, plus a consumer monitor that expects sequential PCs from the last
// redirect/reset target and an instruction derived from each PC.
module tb_if_stage;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid, id_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    logic        mem_go;
    logic [63:0] mq[$];
    logic [63:0] exp_pc;
    int          total = 0, bad = 0, n_pop = 0, n_fire = 0;

    if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .id_ready(id_ready),
        .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // In-order memory: one-cycle latency when mem_go, otherwise holds requests.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready)
                mq.push_back(imem_req_addr);
            imem_rsp_valid <= 1'b0;
            if (mem_go && mq.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= inst_of(mq.pop_front());
            end
        end
    end

    // Consumer monitor: every instruction decode takes must be the next PC.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = RESET_PC;
        end else begin
            if (imem_req_valid && imem_req_ready)
                n_fire++;
            if (redirect_valid) begin
                exp_pc = {redirect_pc[63:2], 2'b00};
            end else if (if_valid && id_ready) begin
                chk("pop_pc", if_pc, exp_pc);
                chk("pop_inst", 64'(if_inst), 64'(inst_of(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                n_pop++;
            end
        end
    end

    task automatic do_reset;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_if_valid(input string tag);
        int n;
        n = 0;
        while (!if_valid && n < 30) begin
            step();
            n++;
        end
        if (!if_valid)
            chk(tag, 64'd0, 64'd1);
    endtask

    initial begin
        int p0, f0;
        rst_n = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1; mem_go = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) step();

        // Reset state
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_pc", if_pc, 64'd0);
        chk("rst_if_inst", 64'(if_inst), 64'(NOP));

        // 1: streaming from reset; credit limit gives 2 pops every 3 cycles
        rst_n = 1'b1;
        #1;
        chk("t1_c0_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_c0_addr", imem_req_addr, 64'h8000_0000);
        step();
        chk("t1_c1_addr", imem_req_addr, 64'h8000_0004);
        chk("t1_c1_if_valid", 64'(if_valid), 64'd0);
        step();
        chk("t1_c2_if_valid", 64'(if_valid), 64'd1);
        chk("t1_c2_if_pc", if_pc, 64'h8000_0000);
        chk("t1_c2_req_valid", 64'(imem_req_valid), 64'd0);
        p0 = n_pop;
        repeat (18) step();
        chk("t1_pops", 64'(n_pop - p0), 64'd12);

        // 2: decode stalled -> exactly DEPTH fetches, then in-order drain
        id_ready = 1'b0;
        do_reset();
        f0 = n_fire;
        repeat (10) step();
        chk("t2_fires", 64'(n_fire - f0), 64'(DEPTH));
        chk("t2_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t2_if_pc", if_pc, 64'h8000_0000);
        id_ready = 1'b1;
        p0 = n_pop;
        repeat (2) step();
        chk("t2_drain_pops", 64'(n_pop - p0), 64'd2);
        chk("t2_drained", 64'(if_valid), 64'd0);
        repeat (6) step();

        // 3: redirect with 2 outstanding, both responses dropped
        mem_go = 1'b0;
        do_reset();
        repeat (4) step();
        chk("t3_blocked", 64'(imem_req_valid), 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        step();
        redirect_valid = 1'b0; mem_go = 1'b1;
        #1;
        chk("t3_new_addr", imem_req_addr, 64'h8000_0100);
        chk("t3_credit_held", 64'(imem_req_valid), 64'd0);
        wait_if_valid("t3_timeout");
        chk("t3_first_pc", if_pc, 64'h8000_0100);
        repeat (4) step();

        // 4: redirect together with a response and a pop
        do_reset();
        repeat (2) step();
        chk("t4_pre_if_valid", 64'(if_valid), 64'd1);
        chk("t4_pre_rsp", 64'(imem_rsp_valid), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t4_flushed", 64'(if_valid), 64'd0);
        chk("t4_if_pc", if_pc, 64'd0);
        chk("t4_if_inst", 64'(if_inst), 64'(NOP));
        chk("t4_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t4_req_addr", imem_req_addr, 64'h8000_0200);
        repeat (2) step();
        chk("t4_if_valid", 64'(if_valid), 64'd1);
        chk("t4_first_pc", if_pc, 64'h8000_0200);

        // 5: low-bit masking, back-to-back redirects, 64-bit PC wrap
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        step();
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("t5_masked", imem_req_addr, 64'h8000_0100);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t5_last_wins", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        begin
            int n;
            n = 0;
            while (!imem_req_valid && n < 30) begin
                step();
                n++;
            end
        end
        chk("t5_issue_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("t5_wrap", imem_req_addr, 64'd0);
        repeat (10) step();

        // 6: asynchronous reset mid-stream, then restart at RESET_PC
        wait_if_valid("t6_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t6_if_valid", 64'(if_valid), 64'd0);
        chk("t6_if_pc", if_pc, 64'd0);
        chk("t6_if_inst", 64'(if_inst), 64'(NOP));
        chk("t6_addr", imem_req_addr, RESET_PC);
        step();
        rst_n = 1'b1;
        #1;
        chk("t6_restart_addr", imem_req_addr, 64'h8000_0000);
        repeat (2) step();
        chk("t6_restart_pc", if_pc, 64'h8000_0000);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
